// File: rtl/enemy_hit_judge.sv
// enemy_hit_judge: per-frame bullet/player vs enemy collision judge driving the enemy boom request
//   clk, rst (async, active-low), clk_move (slow level strobe, sampled in clk domain)
//   x, y scan coordinate; enemy_en / bullet_en / player_en per-pixel opacity; enemyplane_exist
//   boom (explosion request), bullet_kill (1-cycle consume pulse), score (saturating kills), game_over (sticky)
module enemy_hit_judge #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int HOLD_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_move,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       enemy_en,
  input  logic       bullet_en,
  input  logic       player_en,
  input  logic       enemyplane_exist,
  output logic       boom,
  output logic       bullet_kill,
  output logic [7:0] score,
  output logic       game_over
);
  typedef enum logic [1:0] {ARMED, BOOM, RELEASE} state_t;
  state_t     state_q, state_d;
  logic [2:0] sync_q;
  logic [4:0] tick_q, tick_d;
  logic [7:0] score_q, score_d;
  logic       hit_q, hit_d, crash_q, crash_d, kill_q, kill_d, over_q, over_d;
  logic       move_tick, frame_end;
  // clk_move is only a level; its rising edge becomes a single clk pulse
  assign move_tick = sync_q[1] & ~sync_q[2];
  assign frame_end = (x == 10'(H_ACTIVE - 1)) && (y == 10'(V_ACTIVE - 1));
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    score_d = score_q;
    hit_d   = hit_q;
    crash_d = crash_q;
    kill_d  = 1'b0;
    over_d  = over_q;
    case (state_q)
      ARMED: begin
        // include this cycle's coincidence so a frame_end-cycle overlap counts
        hit_d   = hit_q | (enemyplane_exist & enemy_en & bullet_en);
        crash_d = crash_q | (enemyplane_exist & enemy_en & player_en);
        if (frame_end && (hit_d || crash_d)) begin
          state_d = BOOM;
          tick_d  = 5'd0;
          kill_d  = hit_d;
          score_d = (hit_d && score_q != 8'hFF) ? score_q + 8'd1 : score_q;
          over_d  = over_q | crash_d;
          hit_d   = 1'b0;
          crash_d = 1'b0;
        end
      end
      BOOM: begin
        if (move_tick) begin
          tick_d  = tick_q + 5'd1;
          state_d = (tick_q == 5'(HOLD_TICKS - 1)) ? RELEASE : BOOM;
        end
      end
      RELEASE: begin
        // one tick with boom low lets the enemy block clear its own boom counter
        if (move_tick) begin
          state_d = ARMED;
          hit_d   = 1'b0;
          crash_d = 1'b0;
        end
      end
      default: state_d = ARMED;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARMED;
      sync_q  <= 3'd0;
      tick_q  <= 5'd0;
      score_q <= 8'd0;
      hit_q   <= 1'b0;
      crash_q <= 1'b0;
      kill_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], clk_move};
      tick_q  <= tick_d;
      score_q <= score_d;
      hit_q   <= hit_d;
      crash_q <= crash_d;
      kill_q  <= kill_d;
      over_q  <= over_d;
    end
  end
  assign boom        = (state_q == BOOM);
  assign bullet_kill = kill_q;
  assign score       = score_q;
  assign game_over   = over_q;
endmodule
